// File: rtl/score_keeper.sv
// Match controller: BCD scores, serve timing, pause and game-over sequencing.
// Optional macro WIN_BY_TWO_EN enables the deuce rule (lead of two, or reaching 99).
module score_keeper #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 50,
    parameter int unsigned BLINK_HALF  = 25
) (
    input  logic       clk100Hz,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       point_1,
    input  logic       point_2,
    output logic [3:0] score_1_tens,
    output logic [3:0] score_1_ones,
    output logic [3:0] score_2_tens,
    output logic [3:0] score_2_ones,
    output logic       play_en,
    output logic       serve,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       blink
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StServe = 3'd1;
    localparam logic [2:0] StPlay  = 3'd2;
    localparam logic [2:0] StPause = 3'd3;
    localparam logic [2:0] StOver  = 3'd4;

    localparam logic [7:0]  ServeLast = 8'(SERVE_DELAY - 1);
    localparam logic [15:0] BlinkLast = 16'(BLINK_HALF - 1);
    localparam logic [6:0]  WinValue  = 7'(WIN_SCORE);

    logic [2:0]  state_q, state_d;
    logic [7:0]  serve_cnt_q, serve_cnt_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    // Scores held as {tens, ones} BCD bytes.
    logic [7:0]  score_1_q, score_1_d;
    logic [7:0]  score_2_q, score_2_d;
    logic [1:0]  winner_q, winner_d;
    logic        blink_q, blink_d;
    logic        serve_q, serve_d;
    logic        play_en_q;
    logic        game_over_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99) return s;
        if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_value(input logic [7:0] s);
        return 7'(s[7:4]) * 7'd10 + 7'(s[3:0]);
    endfunction

    logic [7:0] inc_1, inc_2;
    logic [6:0] new_1, new_2;
    logic       win_1, win_2;

    assign inc_1 = bcd_inc(score_1_q);
    assign inc_2 = bcd_inc(score_2_q);
    assign new_1 = bcd_value(inc_1);
    assign new_2 = bcd_value(inc_2);

`ifdef WIN_BY_TWO_EN
    logic [6:0] cur_1, cur_2;
    assign cur_1 = bcd_value(score_1_q);
    assign cur_2 = bcd_value(score_2_q);
    // Lead of two required, except that reaching the 99 cap always wins.
    assign win_1 = (new_1 >= WinValue && new_1 >= cur_2 + 7'd2) || new_1 == 7'd99;
    assign win_2 = (new_2 >= WinValue && new_2 >= cur_1 + 7'd2) || new_2 == 7'd99;
`else
    assign win_1 = new_1 >= WinValue;
    assign win_2 = new_2 >= WinValue;
`endif

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        blink_cnt_d = blink_cnt_q;
        score_1_d   = score_1_q;
        score_2_d   = score_2_q;
        winner_d    = winner_q;
        blink_d     = blink_q;
        serve_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StServe;
                    serve_cnt_d = '0;
                end
            end
            StServe: begin
                if (!pause) begin
                    if (serve_cnt_q == ServeLast) begin
                        state_d     = StPlay;
                        serve_cnt_d = '0;
                        serve_d     = 1'b1;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end
            end
            StPlay: begin
                if (point_1 ^ point_2) begin
                    if ((point_1 && win_1) || (point_2 && win_2)) begin
                        state_d     = StOver;
                        winner_d    = point_1 ? 2'b01 : 2'b10;
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else begin
                        state_d     = StServe;
                        serve_cnt_d = '0;
                    end
                    if (point_1) score_1_d = inc_1;
                    else         score_2_d = inc_2;
                end else if (!point_1 && pause) begin
                    // Simultaneous points count as a tick of play, so pause waits.
                    state_d = StPause;
                end
            end
            StPause: begin
                if (!pause) state_d = StPlay;
            end
            StOver: begin
                if (start) begin
                    state_d     = StServe;
                    serve_cnt_d = '0;
                    score_1_d   = '0;
                    score_2_d   = '0;
                    winner_d    = 2'b00;
                    blink_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == BlinkLast) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk100Hz) begin
        if (reset) begin
            state_q     <= StIdle;
            serve_cnt_q <= '0;
            blink_cnt_q <= '0;
            score_1_q   <= '0;
            score_2_q   <= '0;
            winner_q    <= 2'b00;
            blink_q     <= 1'b0;
            serve_q     <= 1'b0;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            score_1_q   <= score_1_d;
            score_2_q   <= score_2_d;
            winner_q    <= winner_d;
            blink_q     <= blink_d;
            serve_q     <= serve_d;
            play_en_q   <= (state_d == StPlay);
            game_over_q <= (state_d == StOver);
        end
    end

    assign score_1_tens = score_1_q[7:4];
    assign score_1_ones = score_1_q[3:0];
    assign score_2_tens = score_2_q[7:4];
    assign score_2_ones = score_2_q[3:0];
    assign play_en      = play_en_q;
    assign serve        = serve_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign blink        = blink_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: integer-score match model checked every cycle, plus directed literals.
module tb_score_keeper;

    localparam int WIN_SCORE   = 11;
    localparam int SERVE_DELAY = 50;
    localparam int BLINK_HALF  = 25;
`ifdef WIN_BY_TWO_EN
    localparam bit WinByTwo = 1'b1;
`else
    localparam bit WinByTwo = 1'b0;
`endif

    logic       clk100Hz = 1'b0;
    logic       reset, start, pause, point_1, point_2;
    logic [3:0] score_1_tens, score_1_ones, score_2_tens, score_2_ones;
    logic       play_en, serve, game_over, blink;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    score_keeper #(
        .WIN_SCORE  (WIN_SCORE),
        .SERVE_DELAY(SERVE_DELAY),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk100Hz    (clk100Hz),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .point_1     (point_1),
        .point_2     (point_2),
        .score_1_tens(score_1_tens),
        .score_1_ones(score_1_ones),
        .score_2_tens(score_2_tens),
        .score_2_ones(score_2_ones),
        .play_en     (play_en),
        .serve       (serve),
        .game_over   (game_over),
        .winner      (winner),
        .blink       (blink)
    );

    always #5 clk100Hz = ~clk100Hz;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match model: plain integer scores, countdown to serve, ticks spent in game-over.
    localparam int PhIdle = 0, PhServe = 1, PhPlay = 2, PhPause = 3, PhOver = 4;
    int m_s1, m_s2, m_phase, m_wait, m_over_ticks, m_winner;
    bit m_serve = 1'b0;
    bit m_valid = 1'b0;

    function automatic bit m_wins(input int mine, input int other);
        return (mine >= WIN_SCORE && (!WinByTwo || mine - other >= 2)) ||
               (WinByTwo && mine == 99);
    endfunction

    always @(posedge clk100Hz) begin
        m_serve = 1'b0;
        if (reset) begin
            m_valid = 1'b1;
            m_s1 = 0; m_s2 = 0; m_phase = PhIdle; m_wait = 0;
            m_over_ticks = 0; m_winner = 0;
        end else if (m_valid) begin
            case (m_phase)
                PhIdle: if (start) begin
                    m_phase = PhServe;
                    m_wait  = SERVE_DELAY;
                end
                PhServe: if (!pause) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_phase = PhPlay;
                        m_serve = 1'b1;
                    end
                end
                PhPlay: begin
                    if (point_1 != point_2) begin
                        bit won;
                        int who;
                        if (point_1) begin
                            m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
                            won = m_wins(m_s1, m_s2);
                            who = 1;
                        end else begin
                            m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
                            won = m_wins(m_s2, m_s1);
                            who = 2;
                        end
                        if (won) begin
                            m_phase = PhOver;
                            m_winner = who;
                            m_over_ticks = 0;
                        end else begin
                            m_phase = PhServe;
                            m_wait = SERVE_DELAY;
                        end
                    end else if (!point_1 && pause) begin
                        m_phase = PhPause;
                    end
                end
                PhPause: if (!pause) m_phase = PhPlay;
                PhOver: begin
                    if (start) begin
                        m_s1 = 0; m_s2 = 0; m_winner = 0;
                        m_phase = PhServe;
                        m_wait = SERVE_DELAY;
                    end else begin
                        m_over_ticks++;
                    end
                end
                default: m_phase = PhIdle;
            endcase
        end
    end

    always @(negedge clk100Hz) begin
        if (m_valid) begin
            chk("score_1_tens", int'(score_1_tens), m_s1 / 10);
            chk("score_1_ones", int'(score_1_ones), m_s1 % 10);
            chk("score_2_tens", int'(score_2_tens), m_s2 / 10);
            chk("score_2_ones", int'(score_2_ones), m_s2 % 10);
            chk("play_en", int'(play_en), int'(m_phase == PhPlay));
            chk("serve", int'(serve), int'(m_serve));
            chk("game_over", int'(game_over), int'(m_phase == PhOver));
            chk("winner", int'(winner), m_winner);
            chk("blink", int'(blink),
                int'(m_phase == PhOver && ((m_over_ticks / BLINK_HALF) % 2 == 0)));
        end
    end

    task automatic step();
        @(posedge clk100Hz);
        #2;
    endtask

    task automatic do_point(input logic a, input logic b);
        point_1 = a;
        point_2 = b;
        step();
        point_1 = 1'b0;
        point_2 = 1'b0;
    endtask

    task automatic wait_serve(output int n);
        n = 0;
        while (!serve && n < 1000) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; point_1 = 1'b0; point_2 = 1'b0;
        step();
        step();
        chk("rst_play_en", int'(play_en), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_scores", int'({score_1_tens, score_1_ones, score_2_tens, score_2_ones}), 0);
        reset = 1'b0;
        repeat (5) step();

        start = 1'b1;
        step();
        start = 1'b0;
        wait_serve(n);
        chk("first_serve_latency", n, 50);
        chk("first_serve_play_en", int'(play_en), 1);

        for (int i = 1; i <= 10; i++) begin
            do_point(1'b1, 1'b0);
            chk("play_en_after_point", int'(play_en), 0);
            wait_serve(n);
            chk("serve_gap", n, 50);
            if (i == 9) chk("p1_ones_at_9", int'(score_1_ones), 9);
        end
        chk("p1_tens_at_10", int'(score_1_tens), 1);
        chk("p1_ones_at_10", int'(score_1_ones), 0);

        do_point(1'b1, 1'b1);
        chk("both_points_ones", int'(score_1_ones), 0);
        chk("both_points_play_en", int'(play_en), 1);

        pause = 1'b1;
        step();
        chk("pause_play_en", int'(play_en), 0);
        do_point(1'b1, 1'b0);
        chk("paused_point_ignored", int'(score_1_ones), 0);
        pause = 1'b0;
        step();
        chk("resume_play_en", int'(play_en), 1);
        chk("resume_no_serve", int'(serve), 0);
        repeat (5) step();

        // Point to player 2, then pause the serve at count 20 for 30 ticks.
        do_point(1'b0, 1'b1);
        repeat (20) step();
        pause = 1'b1;
        repeat (30) step();
        pause = 1'b0;
        wait_serve(n);
        chk("paused_serve_latency", n + 50, 80);

        do_point(1'b1, 1'b0);
        chk("win_game_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 1);
        chk("win_blink_entry", int'(blink), 1);
        repeat (24) step();
        chk("blink_hold", int'(blink), 1);
        step();
        chk("blink_toggle_25", int'(blink), 0);
        repeat (25) step();
        chk("blink_toggle_50", int'(blink), 1);
        do_point(1'b0, 1'b1);
        chk("over_point_ignored", int'(score_2_ones), 1);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_scores", int'({score_1_tens, score_1_ones, score_2_tens, score_2_ones}), 0);
        chk("restart_winner", int'(winner), 0);
        chk("restart_game_over", int'(game_over), 0);
        wait_serve(n);
        chk("restart_serve_latency", n, 50);

        for (int i = 0; i < 10; i++) begin
            do_point(1'b1, 1'b0);
            wait_serve(n);
            do_point(1'b0, 1'b1);
            wait_serve(n);
        end
        chk("deuce_score_1", int'({score_1_tens, score_1_ones}), 16);
        chk("deuce_score_2", int'({score_2_tens, score_2_ones}), 16);
        do_point(1'b1, 1'b0);
`ifdef WIN_BY_TWO_EN
        chk("deuce_11_10_no_win", int'(game_over), 0);
        wait_serve(n);
        do_point(1'b1, 1'b0);
        chk("deuce_12_10_winner", int'(winner), 1);
        chk("deuce_12_10_ones", int'(score_1_ones), 2);
`else
        chk("plain_11_10_game_over", int'(game_over), 1);
        chk("plain_11_10_winner", int'(winner), 1);
`endif

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("mid_serve_reset_scores", int'({score_1_tens, score_1_ones}), 0);
        chk("mid_serve_reset_play_en", int'(play_en), 0);
        chk("mid_serve_reset_winner", int'(winner), 0);
        reset = 1'b0;
        repeat (60) step();
        chk("idle_after_reset_serve", int'(serve), 0);
        chk("idle_after_reset_play_en", int'(play_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
